// File: rtl/eth_xpt_cfg_if.sv
// Header and payload stream from eth_axis_rx into the crosspoint configuration agent.
// The master modport is the upstream parser; the slave modport is the agent.
interface eth_xpt_cfg_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic                  s_eth_hdr_valid;
    logic                  s_eth_hdr_ready;
    logic [15:0]           s_eth_type;
    logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata;
    logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep;
    logic                  s_eth_payload_axis_tvalid;
    logic                  s_eth_payload_axis_tready;
    logic                  s_eth_payload_axis_tlast;
    logic                  s_eth_payload_axis_tuser;

    modport master (
        output s_eth_hdr_valid, s_eth_type,
        output s_eth_payload_axis_tdata, s_eth_payload_axis_tkeep,
        output s_eth_payload_axis_tvalid, s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
        input  s_eth_hdr_ready, s_eth_payload_axis_tready
    );

    modport slave (
        input  s_eth_hdr_valid, s_eth_type,
        input  s_eth_payload_axis_tdata, s_eth_payload_axis_tkeep,
        input  s_eth_payload_axis_tvalid, s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
        output s_eth_hdr_ready, s_eth_payload_axis_tready
    );
endinterface

// File: rtl/eth_xpt_cfg.sv
// Crosspoint configuration agent: stages select bytes from config frames and commits them atomically.
// Define ETH_XPT_CFG_RANGE_CHECK_EN to reject frames carrying a select byte >= S_COUNT.
module eth_xpt_cfg #(
    parameter int          S_COUNT    = 16,
    parameter int          M_COUNT    = 16,
    parameter int          DATA_WIDTH = 64,
    parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
    parameter logic [15:0] ETH_TYPE   = 16'h8099,
    localparam int         SEL_WIDTH  = $clog2(S_COUNT)
) (
    input  logic                           clk,
    input  logic                           rst,
    eth_xpt_cfg_if.slave                   s_eth,
    output logic [M_COUNT*SEL_WIDTH-1:0]   select,
    output logic                           commit,
    output logic [15:0]                    good_count,
    output logic [15:0]                    bad_count
);

    localparam int CNT_WIDTH = $clog2(M_COUNT + 1);

    function automatic logic [M_COUNT*SEL_WIDTH-1:0] identity_select();
        logic [M_COUNT*SEL_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            v[i*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(i % S_COUNT);
        end
        return v;
    endfunction

    localparam logic [M_COUNT*SEL_WIDTH-1:0] SELECT_RESET = identity_select();

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DROP
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic [SEL_WIDTH-1:0]         shadow_q [M_COUNT];
    logic [SEL_WIDTH-1:0]         shadow_d [M_COUNT];
    logic                         range_err_q, range_err_d;
    logic [M_COUNT*SEL_WIDTH-1:0] select_q, select_d;
    logic                         commit_q, commit_d;
    logic [15:0]                  good_q, good_d;
    logic [15:0]                  bad_q, bad_d;

    logic                         beat_err;
    int                           beat_bytes;
    int                           cnt_sum;

    // Ready signals depend only on the registered state, never on valid.
    assign s_eth.s_eth_hdr_ready           = (state_q == IDLE);
    assign s_eth.s_eth_payload_axis_tready = (state_q != IDLE);

`ifdef ETH_XPT_CFG_RANGE_CHECK_EN
    always_comb begin
        beat_err = 1'b0;
        for (int l = 0; l < KEEP_WIDTH; l++) begin
            if (s_eth.s_eth_payload_axis_tkeep[l] && (int'(cnt_q) + l < M_COUNT) &&
                (int'(s_eth.s_eth_payload_axis_tdata[l*8 +: 8]) >= S_COUNT)) begin
                beat_err = 1'b1;
            end
        end
    end
`else
    // Without the range check only the low SEL_WIDTH bits of each byte matter.
    logic unused_tdata;
    assign unused_tdata = ^s_eth.s_eth_payload_axis_tdata;
    assign beat_err     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        range_err_d = range_err_q;
        select_d    = select_q;
        commit_d    = 1'b0;
        good_d      = good_q;
        bad_d       = bad_q;

        beat_bytes = 0;
        for (int l = 0; l < KEEP_WIDTH; l++) begin
            beat_bytes = beat_bytes + int'(s_eth.s_eth_payload_axis_tkeep[l]);
        end
        cnt_sum = int'(cnt_q) + beat_bytes;

        unique case (state_q)
            IDLE: begin
                if (s_eth.s_eth_hdr_valid) begin
                    if (s_eth.s_eth_type == ETH_TYPE) begin
                        state_d     = PAYLOAD;
                        cnt_d       = '0;
                        range_err_d = 1'b0;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PAYLOAD: begin
                if (s_eth.s_eth_payload_axis_tvalid) begin
                    // Byte at lane l lands in shadow slot cnt_q + l when that slot exists.
                    for (int k = 0; k < M_COUNT; k++) begin
                        for (int l = 0; l < KEEP_WIDTH; l++) begin
                            if (s_eth.s_eth_payload_axis_tkeep[l] && (int'(cnt_q) + l == k)) begin
                                shadow_d[k] = s_eth.s_eth_payload_axis_tdata[l*8 +: SEL_WIDTH];
                            end
                        end
                    end
                    cnt_d       = (cnt_sum >= M_COUNT) ? CNT_WIDTH'(M_COUNT) : CNT_WIDTH'(cnt_sum);
                    range_err_d = range_err_q | beat_err;
                    if (s_eth.s_eth_payload_axis_tlast) begin
                        state_d = IDLE;
                        if (!s_eth.s_eth_payload_axis_tuser && (cnt_sum >= M_COUNT) && !range_err_d) begin
                            for (int k = 0; k < M_COUNT; k++) begin
                                select_d[k*SEL_WIDTH +: SEL_WIDTH] = shadow_d[k];
                            end
                            commit_d = 1'b1;
                            good_d   = good_q + 16'd1;
                        end else begin
                            bad_d = bad_q + 16'd1;
                        end
                    end
                end
            end
            DROP: begin
                if (s_eth.s_eth_payload_axis_tvalid && s_eth.s_eth_payload_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            range_err_q <= 1'b0;
            select_q    <= SELECT_RESET;
            commit_q    <= 1'b0;
            good_q      <= '0;
            bad_q       <= '0;
            for (int k = 0; k < M_COUNT; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            range_err_q <= range_err_d;
            select_q    <= select_d;
            commit_q    <= commit_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            shadow_q    <= shadow_d;
        end
    end

    assign select     = select_q;
    assign commit     = commit_q;
    assign good_count = good_q;
    assign bad_count  = bad_q;

endmodule

// File: tb/tb_eth_xpt_cfg.sv
// Scoreboard bench for eth_xpt_cfg: directed frames then random frames against a byte-list model.
// The model follows ETH_XPT_CFG_RANGE_CHECK_EN the same way the design build does.
module tb_eth_xpt_cfg;

    localparam int          S_COUNT    = 16;
    localparam int          M_COUNT    = 16;
    localparam int          DATA_WIDTH = 64;
    localparam int          KEEP_WIDTH = DATA_WIDTH / 8;
    localparam logic [15:0] ETH_TYPE   = 16'h8099;
    localparam int          SEL_WIDTH  = $clog2(S_COUNT);
    localparam int          SELW       = M_COUNT * SEL_WIDTH;

    typedef struct {
        logic [SELW-1:0] sel;
        logic [15:0]     good;
        logic [15:0]     bad;
        logic            commit;
        int              cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [SELW-1:0] select;
    logic            commit;
    logic [15:0]     good_count;
    logic [15:0]     bad_count;

    int              n_cmp  = 0;
    int              n_fail = 0;
    int              cyc    = 0;
    logic            mon_en = 1'b0;
    logic [15:0]     prev_good, prev_bad;
    exp_t            exp_q[$];
    exp_t            mon_e;

    logic [7:0]      fb[$];
    logic [SELW-1:0] model_sel;
    logic [15:0]     model_good, model_bad;
    int              hdr_cyc, first_beat_cyc, last_cyc;
    logic            gap_en = 1'b0;

    eth_xpt_cfg_if #(.DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH)) bus ();

    eth_xpt_cfg #(
        .S_COUNT(S_COUNT), .M_COUNT(M_COUNT), .DATA_WIDTH(DATA_WIDTH),
        .KEEP_WIDTH(KEEP_WIDTH), .ETH_TYPE(ETH_TYPE)
    ) dut (
        .clk(clk), .rst(rst), .s_eth(bus),
        .select(select), .commit(commit), .good_count(good_count), .bad_count(bad_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [SELW-1:0] act, input logic [SELW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [SELW-1:0] identity();
        logic [SELW-1:0] v;
        for (int k = 0; k < M_COUNT; k++) v[k*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(k % S_COUNT);
        return v;
    endfunction

    // Wait until the DUT shows ready at a negedge, then let the edge consume the transfer.
    task automatic waitAccept(input logic is_hdr, output int acc_cyc);
        logic rdy;
        acc_cyc = -1;
        for (int b = 0; b < 1000; b++) begin
            @(negedge clk);
            rdy = is_hdr ? bus.s_eth_hdr_ready : bus.s_eth_payload_axis_tready;
            if (rdy) begin
                acc_cyc = cyc;
                @(posedge clk);
                #1;
                return;
            end
        end
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s_timeout: no ready within 1000 cycles, want ready", is_hdr ? "hdr" : "beat");
    endtask

    task automatic applyStimulus(input logic [15:0] etype, input logic tuser_last, input int abort_beats);
        int   n, nbeats, c;
        logic ok;
        exp_t e;
        n      = fb.size();
        nbeats = (n + KEEP_WIDTH - 1) / KEEP_WIDTH;

        bus.s_eth_hdr_valid = 1'b1;
        bus.s_eth_type      = etype;
        waitAccept(1'b1, hdr_cyc);
        bus.s_eth_hdr_valid = 1'b0;
        bus.s_eth_type      = 16'($urandom);

        for (int b = 0; b < nbeats; b++) begin
            if (abort_beats > 0 && b == abort_beats) return;
            if (gap_en && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            bus.s_eth_payload_axis_tdata = {$urandom, $urandom};
            bus.s_eth_payload_axis_tkeep = '0;
            for (int l = 0; l < KEEP_WIDTH; l++) begin
                if (b * KEEP_WIDTH + l < n) begin
                    bus.s_eth_payload_axis_tdata[l*8 +: 8] = fb[b*KEEP_WIDTH + l];
                    bus.s_eth_payload_axis_tkeep[l]        = 1'b1;
                end
            end
            bus.s_eth_payload_axis_tlast  = (b == nbeats - 1);
            bus.s_eth_payload_axis_tuser  = (b == nbeats - 1) ? tuser_last : 1'b0;
            bus.s_eth_payload_axis_tvalid = 1'b1;
            waitAccept(1'b0, c);
            if (b == 0) first_beat_cyc = c;
            last_cyc = c;
            bus.s_eth_payload_axis_tvalid = 1'b0;
            bus.s_eth_payload_axis_tlast  = 1'b0;
            bus.s_eth_payload_axis_tuser  = 1'b0;
        end

        if (etype != ETH_TYPE) return;
        ok = !tuser_last && (n >= M_COUNT);
`ifdef ETH_XPT_CFG_RANGE_CHECK_EN
        for (int k = 0; k < n && k < M_COUNT; k++) if (fb[k] >= 8'(S_COUNT)) ok = 1'b0;
`endif
        if (ok) begin
            for (int k = 0; k < M_COUNT; k++) model_sel[k*SEL_WIDTH +: SEL_WIDTH] = fb[k][SEL_WIDTH-1:0];
            model_good++;
        end else begin
            model_bad++;
        end
        e.sel = model_sel; e.good = model_good; e.bad = model_bad; e.commit = ok; e.cyc = last_cyc + 1;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            prev_good = good_count;
            prev_bad  = bad_count;
        end else if (commit !== 1'b0 || good_count !== prev_good || bad_count !== prev_bad) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_output: commit=%0b good=%0d bad=%0d, want no change",
                         commit, good_count, bad_count);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("select", select, mon_e.sel);
                checkOutput("good_count", SELW'(good_count), SELW'(mon_e.good));
                checkOutput("bad_count", SELW'(bad_count), SELW'(mon_e.bad));
                checkOutput("commit", SELW'(commit), SELW'(mon_e.commit));
                checkOutput("update_cycle", SELW'(cyc), SELW'(mon_e.cyc));
            end
            prev_good = good_count;
            prev_bad  = bad_count;
        end
    end

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_select"}, select, identity());
        checkOutput({tag, "_good"}, SELW'(good_count), '0);
        checkOutput({tag, "_bad"}, SELW'(bad_count), '0);
        checkOutput({tag, "_commit"}, SELW'(commit), '0);
        checkOutput({tag, "_hdr_ready"}, SELW'(bus.s_eth_hdr_ready), SELW'(1));
        checkOutput({tag, "_tready"}, SELW'(bus.s_eth_payload_axis_tready), '0);
    endtask

    task automatic fillFrame(input int n, input int mode);
        fb.delete();
        for (int k = 0; k < n; k++) begin
            if (mode == 0) fb.push_back(8'(15 - k));
            else if ($urandom_range(0, 9) == 0) fb.push_back(8'($urandom_range(16, 255)));
            else fb.push_back(8'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int tl1;
        rst = 1'b1;
        bus.s_eth_hdr_valid = 1'b0;
        bus.s_eth_type = '0;
        bus.s_eth_payload_axis_tdata = '0;
        bus.s_eth_payload_axis_tkeep = '0;
        bus.s_eth_payload_axis_tvalid = 1'b0;
        bus.s_eth_payload_axis_tlast = 1'b0;
        bus.s_eth_payload_axis_tuser = 1'b0;
        model_sel = identity(); model_good = '0; model_bad = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkIdle("reset");
        mon_en = 1'b1;

        fillFrame(16, 0);
        applyStimulus(ETH_TYPE, 1'b0, 0);
        fillFrame(12, 1);
        applyStimulus(ETH_TYPE, 1'b0, 0);
        fillFrame(16, 1);
        applyStimulus(ETH_TYPE, 1'b1, 0);

        fillFrame(20, 1);
        applyStimulus(16'h0800, 1'b0, 0);
        tl1 = last_cyc;
        fillFrame(16, 1);
        for (int k = 0; k < 16; k++) fb[k] = 8'(k ^ 5);
        applyStimulus(ETH_TYPE, 1'b0, 0);
        checkOutput("hdr2_accept_cycle", SELW'(hdr_cyc), SELW'(tl1 + 1));
        checkOutput("first_beat_cycle", SELW'(first_beat_cyc), SELW'(hdr_cyc + 1));

        fillFrame(16, 0);
        fb[3] = 8'h20;
        applyStimulus(ETH_TYPE, 1'b0, 0);

        fillFrame(16, 1);
        applyStimulus(ETH_TYPE, 1'b0, 1);
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_sel = identity(); model_good = '0; model_bad = '0;
        checkIdle("midframe_reset");
        mon_en = 1'b1;

        gap_en = 1'b1;
        for (int f = 0; f < 60; f++) begin
            fillFrame(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(16, 24)), 1);
            applyStimulus(($urandom_range(0, 4) == 0) ? 16'(16'h0800 + $urandom_range(0, 3)) : ETH_TYPE,
                          ($urandom_range(0, 7) == 0), 0);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", SELW'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
